// File: rtl/eta2_pkg.sv
// Shared FSM encodings and configuration helpers for the ETA-II pipelined adder.
package eta2_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StEmpty = 2'd0;
    localparam state_t StFull  = 2'd1;
    localparam state_t StFix   = 2'd2;

    function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

    // Operands must split into whole segments and the window must leave segment 0 outside it.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned seg,
                                  input int unsigned spec_segs);
        return (seg != 0) && (width % seg == 0) && (spec_segs >= 1)
            && (spec_segs + 1 <= width / seg);
    endfunction

endpackage

// File: rtl/eta_seg_adder.sv
// One SEG-bit segment adder with carry-in and carry-out.
module eta_seg_adder #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic [SEG:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    assign sum   = total[SEG-1:0];
    assign cout  = total[SEG];

endmodule

// File: rtl/eta2_pipe_adder.sv
// Handshaked ETA-II approximate adder with optional one-cycle exact correction
// and a saturating count of delivered approximate-mode errors.
module eta2_pipe_adder
    import eta2_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SEG       = 4,
    parameter int unsigned SPEC_SEGS = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_err,
    output logic             out_exact,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned NSEG = calc_nseg(WIDTH, SEG);

    if (!cfg_ok(WIDTH, SEG, SPEC_SEGS)) begin : g_bad_cfg
        $error("eta2_pipe_adder: illegal WIDTH/SEG/SPEC_SEGS combination");
    end

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cout_q, err_q, exact_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] op_a, op_b, s0, s1, true_sum, spec_sum;
    logic [NSEG-1:0]  co0, co1;
    logic [NSEG:0]    true_c, spec_c;
    logic             err, accept, out_xfer;

    // In FIX the adder recomputes the stored operands to produce the true sum.
    assign op_a = (state_q == StFix) ? a_q : in_a;
    assign op_b = (state_q == StFix) ? b_q : in_b;

    // Each segment is summed for both carry-in values; true and speculative paths select.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        eta_seg_adder #(.SEG(SEG)) u_add0 (
            .a   (op_a[k*SEG +: SEG]),
            .b   (op_b[k*SEG +: SEG]),
            .cin (1'b0),
            .sum (s0[k*SEG +: SEG]),
            .cout(co0[k])
        );
        eta_seg_adder #(.SEG(SEG)) u_add1 (
            .a   (op_a[k*SEG +: SEG]),
            .b   (op_b[k*SEG +: SEG]),
            .cin (1'b1),
            .sum (s1[k*SEG +: SEG]),
            .cout(co1[k])
        );
        assign true_sum[k*SEG +: SEG] = true_c[k] ? s1[k*SEG +: SEG] : s0[k*SEG +: SEG];
        assign spec_sum[k*SEG +: SEG] = spec_c[k] ? s1[k*SEG +: SEG] : s0[k*SEG +: SEG];
    end

    always_comb begin
        int   lo;
        logic c;
        lo     = 0;
        c      = 1'b0;
        true_c = '0;
        spec_c = '0;
        for (int k = 0; k < int'(NSEG); k++) begin
            true_c[k+1] = true_c[k] ? co1[k] : co0[k];
        end
        // Carry into k (k == NSEG is the carry-out) ripples only through the window below k.
        for (int k = 1; k <= int'(NSEG); k++) begin
            lo = (k > int'(SPEC_SEGS)) ? k - int'(SPEC_SEGS) : 0;
            c  = 1'b0;
            for (int j = 0; j < int'(NSEG); j++) begin
                if (j >= lo && j < k) c = c ? co1[j] : co0[j];
            end
            spec_c[k] = c;
        end
    end

    assign err       = |(spec_c[NSEG:1] ^ true_c[NSEG:1]);
    assign out_valid = (state_q == StFull);
    assign in_ready  = rst_n && ((state_q == StEmpty) || (out_valid && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            exact_q <= 1'b0;
        end else if (state_q == StFix) begin
            state_q <= StFull;
            sum_q   <= true_sum;
            cout_q  <= true_c[NSEG];
            err_q   <= 1'b1;
        end else if (accept) begin
            exact_q <= in_exact;
            if (in_exact && err) begin
                state_q <= StFix;
                a_q     <= in_a;
                b_q     <= in_b;
            end else begin
                state_q <= StFull;
                sum_q   <= spec_sum;
                cout_q  <= spec_c[NSEG];
                err_q   <= err;
            end
        end else if (out_xfer) begin
            state_q <= StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (out_xfer && err_q && !exact_q && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_err   = err_q;
    assign out_exact = exact_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_eta2_pipe_adder.sv
// Directed bench for eta2_pipe_adder: scoreboarded results, latency, backpressure,
// counter saturation/clear, reset during correction, and a SPEC_SEGS=2 instance.
module tb_eta2_pipe_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        err;
        logic        ex;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_exact, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_sum;
    logic        out_cout, out_err, out_exact, clr_cnt;
    logic [3:0]  err_count;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, out_cout2, out_err2, out_exact2;
    logic        clr_cnt2;
    logic [15:0] out_sum2, err_count2;

    exp_t        sb[$];
    logic [3:0]  exp_cnt = 4'd0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    eta2_pipe_adder #(.WIDTH(16), .SEG(4), .SPEC_SEGS(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_exact(in_exact), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err),
        .out_exact(out_exact), .clr_cnt(clr_cnt), .err_count(err_count)
    );

    eta2_pipe_adder #(.WIDTH(16), .SEG(4), .SPEC_SEGS(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_exact(in_exact), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_sum(out_sum2), .out_cout(out_cout2), .out_err(out_err2),
        .out_exact(out_exact2), .clr_cnt(clr_cnt2), .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: carry into segment k is the carry out of the plain sum of the window bits.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ex,
                                   input int spec);
        exp_t        r;
        logic [16:0] mask, wa, wb, ws, tru;
        logic [4:0]  scin, tcin;
        logic [15:0] ssum;
        logic        e;
        int          lo, n;
        scin = '0;
        tcin = '0;
        ssum = '0;
        for (int k = 1; k <= 4; k++) begin
            mask    = (17'd1 << (4 * k)) - 17'd1;
            ws      = ({1'b0, a} & mask) + ({1'b0, b} & mask);
            tcin[k] = ws[4*k];
            lo      = (k > spec) ? k - spec : 0;
            n       = 4 * (k - lo);
            mask    = (17'd1 << n) - 17'd1;
            wa      = ({1'b0, a} >> (4 * lo)) & mask;
            wb      = ({1'b0, b} >> (4 * lo)) & mask;
            ws      = wa + wb;
            scin[k] = ws[n];
        end
        for (int k = 0; k < 4; k++) begin
            ssum[4*k +: 4] = a[4*k +: 4] + b[4*k +: 4] + {3'b000, scin[k]};
        end
        e      = |(scin[4:1] ^ tcin[4:1]);
        tru    = {1'b0, a} + {1'b0, b};
        r.sum  = (ex && e) ? tru[15:0] : ssum;
        r.cout = (ex && e) ? tru[16] : scin[4];
        r.err  = e;
        r.ex   = ex;
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ex,
                        output int waits);
        waits    = 0;
        in_a     = a;
        in_b     = b;
        in_exact = ex;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waits < 40) begin
            @(negedge clk);
            #2;
            waits++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(model(a, b, ex, 1));
            @(negedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor: samples mid-cycle; a transfer happens at the following rising edge.
    initial begin : monitor
        exp_t e;
        logic xfer, have_e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("err_count", 32'(err_count), 32'(exp_cnt));
                xfer   = out_valid && out_ready;
                have_e = 1'b0;
                e      = '0;
                if (xfer) begin
                    if (sb.size() == 0) begin
                        chk("out_without_pending", 32'(out_valid), 32'd0);
                    end else begin
                        e      = sb.pop_front();
                        have_e = 1'b1;
                        chk("sb_sum", 32'(out_sum), 32'(e.sum));
                        chk("sb_cout", 32'(out_cout), 32'(e.cout));
                        chk("sb_err", 32'(out_err), 32'(e.err));
                        chk("sb_exact", 32'(out_exact), 32'(e.ex));
                    end
                end
                if (clr_cnt) exp_cnt = 4'd0;
                else if (have_e && e.err && !e.ex && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          w;
        exp_t        h, e2;
        logic [15:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; in_a = '0; in_b = '0;
        in_exact = 1'b0; out_ready = 1'b0; out_ready2 = 1'b1; clr_cnt = 1'b0; clr_cnt2 = 1'b0;
        step(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Approximate, no error
        send(16'h1234, 16'h1111, 1'b0, w);
        chk("approx_latency", 32'(out_valid), 32'd1);
        chk("approx_sum", 32'(out_sum), 32'h2345);
        chk("approx_err", 32'(out_err), 32'd0);
        step(1);

        // Approximate, error
        send(16'h00FF, 16'h0001, 1'b0, w);
        chk("approx_err_sum", 32'(out_sum), 32'h0000);
        chk("approx_err_flag", 32'(out_err), 32'd1);
        step(1);
        chk("cnt_after_err", 32'(err_count), 32'd1);

        // Exact mode with error: FIX cycle, then corrected result
        send(16'hFFFF, 16'h0001, 1'b1, w);
        chk("fix_in_ready", 32'(in_ready), 32'd0);
        chk("fix_out_valid", 32'(out_valid), 32'd0);
        step(1);
        chk("exact_latency", 32'(out_valid), 32'd1);
        chk("exact_sum", 32'(out_sum), 32'h0000);
        chk("exact_cout", 32'(out_cout), 32'd1);
        chk("exact_err", 32'(out_err), 32'd1);
        step(1);
        chk("cnt_after_exact", 32'(err_count), 32'd1);
        send(16'hFFFF, 16'h0001, 1'b0, w);
        chk("approx_ffff_sum", 32'(out_sum), 32'hFF00);
        chk("approx_ffff_cout", 32'(out_cout), 32'd0);
        chk("approx_ffff_err", 32'(out_err), 32'd1);
        step(1);

        // Backpressure: held output, no accept
        out_ready = 1'b0;
        send(16'hABCD, 16'h1357, 1'b0, w);
        h = model(16'hABCD, 16'h1357, 1'b0, 1);
        in_a = 16'h0F0F; in_b = 16'h0101; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_sum", 32'(out_sum), 32'(h.sum));
            chk("bp_out_err", 32'(out_err), 32'(h.err));
            step(1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(ra, rb, 1'b0, w);
            chk("stream_wait", 32'(w), 32'd0);
        end
        step(2);
        chk("stream_drained", 32'(sb.size()), 32'd0);

        // Counter saturation and clear priority
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        chk("cnt_cleared", 32'(err_count), 32'd0);
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0) send(16'h00FF, 16'h0001, 1'b0, w);
            else send(16'h0FF0, 16'h0010, 1'b0, w);
        end
        step(2);
        chk("cnt_saturated", 32'(err_count), 32'hF);
        send(16'h00FF, 16'h0001, 1'b0, w);
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        chk("cnt_clr_wins", 32'(err_count), 32'd0);

        // Reset during FIX
        send(16'h1234, 16'h1111, 1'b0, w);
        step(1);
        send(16'hFFFF, 16'h0001, 1'b1, w);
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = 4'd0;
        #1;
        chk("rfix_out_valid", 32'(out_valid), 32'd0);
        chk("rfix_out_sum", 32'(out_sum), 32'd0);
        chk("rfix_out_cout", 32'(out_cout), 32'd0);
        chk("rfix_out_err", 32'(out_err), 32'd0);
        chk("rfix_out_exact", 32'(out_exact), 32'd0);
        chk("rfix_in_ready", 32'(in_ready), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("rfix_no_stale", 32'(out_valid), 32'd0);
        send(16'h1111, 16'h2222, 1'b0, w);
        step(2);

        // SPEC_SEGS=2 instance
        in_a = 16'h00FF; in_b = 16'h0001; in_exact = 1'b0; in_valid2 = 1'b1;
        e2 = model(16'h00FF, 16'h0001, 1'b0, 2);
        #1;
        chk("s2_in_ready", 32'(in_ready2), 32'd1);
        step(1);
        chk("s2_out_valid", 32'(out_valid2), 32'd1);
        chk("s2_sum", 32'(out_sum2), 32'h0100);
        chk("s2_sum_model", 32'(out_sum2), 32'(e2.sum));
        chk("s2_err", 32'(out_err2), 32'd0);
        chk("s2_cout", 32'(out_cout2), 32'd0);
        in_a = 16'hFFFF; in_b = 16'h0001;
        e2 = model(16'hFFFF, 16'h0001, 1'b0, 2);
        step(1);
        in_valid2 = 1'b0;
        chk("s2_ffff_sum", 32'(out_sum2), 32'(e2.sum));
        chk("s2_ffff_sum_lit", 32'(out_sum2), 32'hF000);
        chk("s2_ffff_err", 32'(out_err2), 32'd1);
        step(1);
        chk("s2_err_count", 32'(err_count2), 32'd1);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eta2_pipe_adder.md
Name: eta2_pipe_adder

Overview:
Parametrised, handshaked successor to the team's 16-bit ETA-II approximate adder. It splits operands into SEG-bit segments and speculates each segment's carry-in from a window of lower segments. It detects speculation errors and, per transaction, either returns the approximate result (flagged) or corrects it to the exact sum with one extra cycle. It sits in the CNN datapath between operand producers and accumulators, and keeps a saturating count of approximate-mode errors for accuracy profiling.

Parameters:
WIDTH, 16, operand and sum width; must be a multiple of SEG.
SEG, 4, segment width in bits.
SPEC_SEGS, 1, number of lower segments in the carry-speculation window; 1 gives classic ETA-II; range 1..WIDTH/SEG-1.
CNT_W, 16, width of the error counter.

Ports:
clk  in  1  clock; single clock domain.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand transaction valid.
in_ready  out  1  block can accept an operand transaction.
in_a  in  WIDTH  operand A, unsigned.
in_b  in  WIDTH  operand B, unsigned.
in_exact  in  1  1 = exact mode (correct on error); 0 = approximate mode.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_sum  out  WIDTH  result sum.
out_cout  out  1  carry-out: speculative in approximate mode, true in exact mode.
out_err  out  1  1 = speculation error occurred; result inexact (approximate mode) or corrected (exact mode).
out_exact  out  1  echo of in_exact for this result.
clr_cnt  in  1  synchronous clear of err_count.
err_count  out  CNT_W  saturating count of erroneous approximate results delivered.

Behaviour:
- Interface: clock and reset are clk and rst_n; one clock; rst_n is asynchronous, active-low.
- Segmentation:
  - NSEG = WIDTH/SEG segments; segment 0 has carry-in 0.
  - Speculative carry-in of segment k (k>=1) = carry-out of segments max(0,k-SPEC_SEGS)..k-1, ripple-added with carry-in 0 at the window base.
  - Speculative cout = carry-out of the top SPEC_SEGS segments, computed the same way.
- Error detection:
  - err = OR over k of (speculative cin[k] != true ripple cin[k]), including cout.
  - Errors only under-estimate the true carry.
- Handshake:
  - Input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
  - out_* are stable while out_valid && !out_ready.
- FSM states:
  - EMPTY: in_ready=1, out_valid=0. On accept: if in_exact && err, store operands and go to FIX; otherwise register the approximate result (or exact, which is identical when err=0) and go to FULL.
  - FIX: in_ready=0, out_valid=0. Next cycle: register the true sum, true cout and out_err=1, then go to FULL.
  - FULL: out_valid=1; in_ready = out_ready (combinational). On output transfer with no new accept, go to EMPTY. On simultaneous output transfer and input accept, apply the EMPTY accept rules.
- Latency and throughput:
  - 1 cycle from accept to out_valid for approximate mode, and for exact mode without error.
  - 2 cycles for exact mode with error.
  - Throughput is 1 result per cycle without corrections.
- err_count:
  - Increments on an output transfer with out_err=1 && out_exact=0.
  - Saturates at all-ones.
  - clr_cnt wins over a simultaneous increment.
- Reset (asynchronous, including mid-FIX or FULL):
  - State goes to EMPTY; any in-flight transaction is dropped.
  - out_valid, out_sum, out_cout, out_err, out_exact and err_count all reset to 0.
  - in_ready is forced to 0 while rst_n is low.

Decomposition:
- Package eta2_pkg: FSM state enum (EMPTY, FULL, FIX); localparam helpers for NSEG; a compile-time check that WIDTH % SEG == 0 and that SPEC_SEGS is in range.
- Sub-module eta_seg_adder: SEG-bit adder with cin, producing sum and cout. It is instantiated for the speculative sum path and the true ripple path, with generate loops over segments and the window.

Test Plan:
- Approximate, no error: WIDTH=16/SEG=4/SPEC=1, A=0x1234, B=0x1111, exact=0 -> one cycle later sum=0x2345, cout=0, err=0.
- Approximate, error: A=0x00FF, B=0x0001, exact=0 -> sum=0x0000, err=1; after output transfer, err_count=1.
- Exact mode, error: A=0xFFFF, B=0x0001, exact=1 -> in_ready low for one cycle (FIX); two cycles after accept sum=0x0000, cout=1, err=1; err_count unchanged. The same operands in approximate mode give sum=0xFF00, cout=0, err=1.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> outputs held stable, in_ready=0, no input accepted. Then out_ready=1 -> back-to-back 1/cycle stream of 8 results, in order.
- Counter: CNT_W=4, 17 erroneous approximate results -> err_count=15 (saturated). clr_cnt together with an erroneous transfer -> err_count=0.
- Reset mid-FIX: deassert rst_n during FIX -> out_valid=0, outputs zero, no stale result emitted after release. Repeat the adder checks with SPEC_SEGS=2: 0x00FF+0x0001 gives the exact result 0x0100 with err=0.
